// File: rtl/vga_frame_reader.sv
// 640x480@60 scanout of a scaled greyscale image window read from a synchronous pixel memory.
// Optional one-pixel white frame around the window: define VGA_FRAME_READER_BORDER_EN.
module vga_frame_reader #(
   parameter int IMG_W      = 32,
   parameter int IMG_H      = 32,
   parameter int SCALE_LOG2 = 3,
   parameter int X0         = 192,
   parameter int Y0         = 112,
   parameter int BASE_ADR   = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic [9:0] vga_adr,
   input  logic [7:0] vga_pixel,
   output logic       vga_clk,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       blank_n,
   output logic [7:0] r,
   output logic [7:0] g,
   output logic [7:0] b,
   output logic       frame_start
);

   localparam logic [9:0] H_LAST   = 10'd799;
   localparam logic [9:0] V_LAST   = 10'd524;
   localparam logic [9:0] H_VIS    = 10'd640;
   localparam logic [9:0] V_VIS    = 10'd480;
   localparam logic [9:0] HS_FIRST = 10'd656;
   localparam logic [9:0] HS_LAST  = 10'd751;
   localparam logic [9:0] VS_FIRST = 10'd490;
   localparam logic [9:0] VS_LAST  = 10'd491;
   localparam int         X1       = X0 + (IMG_W << SCALE_LOG2);
   localparam int         Y1       = Y0 + (IMG_H << SCALE_LOG2);
   localparam logic [9:0] BASE10   = 10'(BASE_ADR);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t     state, nextState;
   logic       phase, tick;
   logic [9:0] h, v;

   logic       visible, hsyncN, vsyncN, inWin, onRing;
   logic [9:0] colIdx, rowIdx, winAdr;

   // First-stage copies of the decode, aligned with the memory read latency
   logic       hs1, vs1, bl1, win1, ring1;
   logic [7:0] pix;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      nextState = state;
      tick      = 1'b0;
      case (state)
         IDLE:    if (enable) nextState = SCAN;
         SCAN:    if (!enable) nextState = IDLE;
                  else tick = ~phase;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         phase <= 1'b0;
         h     <= '0;
         v     <= '0;
      end else if (!enable) begin
         phase <= 1'b0;
         h     <= '0;
         v     <= '0;
      end else if (state == SCAN) begin
         phase <= ~phase;
         if (tick) begin
            if (h == H_LAST) begin
               h <= '0;
               v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
            end else begin
               h <= h + 10'd1;
            end
         end
      end
   end

   assign visible = (h < H_VIS) && (v < V_VIS);
   assign hsyncN  = !((h >= HS_FIRST) && (h <= HS_LAST));
   assign vsyncN  = !((v >= VS_FIRST) && (v <= VS_LAST));
   assign inWin   = (int'(h) >= X0) && (int'(h) < X1) && (int'(v) >= Y0) && (int'(v) < Y1);

`ifdef VGA_FRAME_READER_BORDER_EN
   assign onRing = !inWin && (int'(h) >= X0 - 1) && (int'(h) <= X1)
                          && (int'(v) >= Y0 - 1) && (int'(v) <= Y1);
`else
   assign onRing = 1'b0;
`endif

   // Address arithmetic wraps mod 1024 by construction of the 10-bit terms
   assign colIdx = (h - 10'(X0)) >> SCALE_LOG2;
   assign rowIdx = (v - 10'(Y0)) >> SCALE_LOG2;
   assign winAdr = BASE10 + 10'(rowIdx * IMG_W) + colIdx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vga_adr     <= BASE10;
         vga_clk     <= 1'b0;
         frame_start <= 1'b0;
         hs1         <= 1'b1;
         vs1         <= 1'b1;
         bl1         <= 1'b0;
         win1        <= 1'b0;
         ring1       <= 1'b0;
         hsync_n     <= 1'b1;
         vsync_n     <= 1'b1;
         blank_n     <= 1'b0;
         pix         <= 8'h00;
      end else if (!enable) begin
         vga_adr     <= BASE10;
         vga_clk     <= 1'b0;
         frame_start <= 1'b0;
         hs1         <= 1'b1;
         vs1         <= 1'b1;
         bl1         <= 1'b0;
         win1        <= 1'b0;
         ring1       <= 1'b0;
         hsync_n     <= 1'b1;
         vsync_n     <= 1'b1;
         blank_n     <= 1'b0;
         pix         <= 8'h00;
      end else begin
         vga_clk     <= tick;
         frame_start <= tick && (h == 10'd0) && (v == 10'd0);
         if (tick) begin
            vga_adr <= inWin ? winAdr : BASE10;
            hs1     <= hsyncN;
            vs1     <= vsyncN;
            bl1     <= visible;
            win1    <= inWin;
            ring1   <= onRing;
            hsync_n <= hs1;
            vsync_n <= vs1;
            blank_n <= bl1;
            if (bl1 && win1)       pix <= vga_pixel;
            else if (bl1 && ring1) pix <= 8'hFF;
            else                   pix <= 8'h00;
         end
      end
   end

   assign r = pix;
   assign g = pix;
   assign b = pix;

endmodule
